id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter XLEN, 32, datapath and PC width; only 32 is supported.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 if_valid  input  1  fetch presents an instruction.
REQ-005 if_ready  output  1  stage accepts the instruction this cycle.
REQ-006 if_instr  input  32  raw instruction, interpreted as instruction_t.
REQ-007 if_pc  input  XLEN  PC of if_instr.
REQ-008 flush  input  1  discard the held instruction (branch redirect).
REQ-009 id_valid  output  1  decoded instruction held.
REQ-010 id_ready  input  1  execute consumes the held instruction.
REQ-011 id_pc  output  XLEN  PC of the held instruction.
REQ-012 id_opcode/id_funct3/id_funct7  output  7/3/7  decoded fields.
REQ-013 id_rs1/id_rs2/id_rd  output  5/5/5  register indices.
REQ-014 id_imm  output  32  sign-extended immediate.
REQ-015 id_reg_write  output  1  instruction writes rd.
REQ-016 id_illegal  output  1  instruction is not a supported encoding.

Function
REQ-017 The stage SHALL be a single-entry registered pipeline stage with 1-cycle latency: fields appear on outputs the cycle after acceptance.
- if_ready = !id_valid || id_ready (combinational; no dependence on if_valid).
- Load when if_valid && if_ready; id_valid set next cycle.
- id_valid cleared when id_ready && !load.
- Outputs held stable while id_valid && !id_ready.
REQ-018 flush SHALL have priority: next cycle id_valid=0 regardless of load or id_ready; a same-cycle accepted instruction is discarded.
REQ-019 Immediate per opcode:
- I (IMM, JALR, L): sext(instr[31:20]).
- S: sext({imm11_5, imm4_0}).
- B: sext({imm12, imm11, imm10_5, imm4_1, 0}).
- U (LUI, AUIPC): {instr[31:12], 12'b0}.
- J: sext({imm20, imm19_12, imm11, imm10_1, 0}).
- OP and illegal: 0.
REQ-020 id_rs1 SHALL be 0 for LUI, AUIPC, JAL; id_rs2 SHALL be 0 except OP, S, BRANCH; id_rd SHALL be 0 for S and BRANCH.
REQ-021 id_illegal SHALL be 1 for:
- opcode outside opcodes;
- BRANCH funct3 010/011;
- S funct3 > 010;
- L funct3 011/110/111;
- JALR funct3 != 000;
- OP funct7 not 0000000/0100000, or 0100000 with funct3 not ADD/SRL;
- IMM SLL with imm[11:5] != 0, or SRL with imm[11:5] not 0000000/0100000.
REQ-022 id_reg_write = !id_illegal && rd != 0 && opcode in {LUI, AUIPC, JAL, JALR, IMM, OP, L}.

Reset
REQ-023 While rst is high, all output registers SHALL be 0 (id_valid=0, id_illegal=0, id_reg_write=0), applied asynchronously; if_ready=1 during and after reset.
REQ-024 Reset mid-transfer SHALL drop the held instruction; no output toggles on deassertion until the next load.

Structure
REQ-025 opcodes, funct3 enums, ASUB, the format structs and instruction_t SHALL come from the shared typePack package; the immediate-format enum (I/S/B/U/J/NONE) SHALL be added there.
REQ-026 Decode SHALL be a combinational sub-module id_decode (instruction_t in, fields/imm/flags out); id_stage holds the handshake and register.

Verification
REQ-027 0xFFF00093 (ADDI x1,x0,-1) -> next cycle id_opcode=IMM, id_rd=1, id_imm=0xFFFFFFFF, id_reg_write=1.
REQ-028 0x0020A423 (SW x2,8(x1)) -> id_rs1=1, id_rs2=2, id_rd=0, id_imm=8, id_reg_write=0.
REQ-029 0xFE000EE3 (BEQ -4) -> id_imm=0xFFFFFFFC; 0x001000EF (JAL x1,2048) -> id_imm=0x00000800, id_rs1=0, id_reg_write=1.
REQ-030 id_valid=1, id_ready=0, if_valid=1 for 3 cycles -> if_ready=0, outputs unchanged; id_ready=1 -> new instruction next cycle.
REQ-031 flush and load in the same cycle -> id_valid=0 next cycle; 0x00000000 -> id_illegal=1, id_reg_write=0.
REQ-032 rst pulsed between clock edges while id_valid=1 -> id_valid=0 immediately, if_ready=1.

Source files
------------

// File: rtl/typePack.sv
// Shared RV32I encoding types: opcodes, funct3 codes, instruction formats
// and the immediate-format selector used by the decode stage.
package typePack;

    localparam int unsigned ILEN = 32;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_L      = 7'b0000011,
        OPC_S      = 7'b0100011,
        OPC_IMM    = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opcode_e;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } branch_f3_e;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_f3_e;

    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010
    } store_f3_e;

    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SLL  = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SRL  = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } alu_f3_e;

    // funct7 marking SUB / SRA (and SRAI in imm[11:5])
    localparam logic [6:0] ASUB = 7'b0100000;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_e;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        opcode_e    opcode;
    } r_type_t;

    typedef struct packed {
        logic [11:0] imm11_0;
        logic [4:0]  rs1;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        opcode_e     opcode;
    } i_type_t;

    typedef struct packed {
        logic [6:0] imm11_5;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] imm4_0;
        opcode_e    opcode;
    } s_type_t;

    typedef struct packed {
        logic       imm12;
        logic [5:0] imm10_5;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [3:0] imm4_1;
        logic       imm11;
        opcode_e    opcode;
    } b_type_t;

    typedef struct packed {
        logic [19:0] imm31_12;
        logic [4:0]  rd;
        opcode_e     opcode;
    } u_type_t;

    typedef struct packed {
        logic       imm20;
        logic [9:0] imm10_1;
        logic       imm11;
        logic [7:0] imm19_12;
        logic [4:0] rd;
        opcode_e    opcode;
    } j_type_t;

    typedef union packed {
        r_type_t r;
        i_type_t i;
        s_type_t s;
        b_type_t b;
        u_type_t u;
        j_type_t j;
    } instruction_t;

endpackage

// File: rtl/id_decode.sv
// Combinational RV32I field/immediate decode with legality and
// register-write qualification.
module id_decode
    import typePack::*;
(
    input  instruction_t instr,
    output logic [6:0]   opcode_c,
    output logic [2:0]   funct3_c,
    output logic [6:0]   funct7_c,
    output logic [4:0]   rs1_c,
    output logic [4:0]   rs2_c,
    output logic [4:0]   rd_c,
    output logic [31:0]  imm_c,
    output logic         reg_write_c,
    output logic         illegal_c
);

    imm_fmt_e   fmt;
    logic       writes_rd;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       uses_rd;
    logic [2:0] f3;
    logic [6:0] f7;

    assign f3 = instr.r.funct3;
    assign f7 = instr.r.funct7;

    // Per-opcode format, register usage and encoding legality
    always_comb begin
        fmt       = IMM_NONE;
        illegal_c = 1'b1;
        writes_rd = 1'b0;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b0;
        uses_rd   = 1'b1;
        case (instr.r.opcode)
            OPC_LUI, OPC_AUIPC: begin
                fmt       = IMM_U;
                illegal_c = 1'b0;
                writes_rd = 1'b1;
                uses_rs1  = 1'b0;
            end
            OPC_JAL: begin
                fmt       = IMM_J;
                illegal_c = 1'b0;
                writes_rd = 1'b1;
                uses_rs1  = 1'b0;
            end
            OPC_JALR: begin
                fmt       = IMM_I;
                illegal_c = (f3 != 3'b000);
                writes_rd = 1'b1;
            end
            OPC_BRANCH: begin
                fmt       = IMM_B;
                illegal_c = !(f3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU});
                uses_rs2  = 1'b1;
                uses_rd   = 1'b0;
            end
            OPC_L: begin
                fmt       = IMM_I;
                illegal_c = !(f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
                writes_rd = 1'b1;
            end
            OPC_S: begin
                fmt       = IMM_S;
                illegal_c = !(f3 inside {F3_SB, F3_SH, F3_SW});
                uses_rs2  = 1'b1;
                uses_rd   = 1'b0;
            end
            OPC_IMM: begin
                fmt       = IMM_I;
                illegal_c = ((f3 == F3_SLL) && (f7 != 7'b0000000)) ||
                            ((f3 == F3_SRL) && !((f7 == 7'b0000000) || (f7 == ASUB)));
                writes_rd = 1'b1;
            end
            OPC_OP: begin
                fmt       = IMM_NONE;
                illegal_c = !((f7 == 7'b0000000) ||
                              ((f7 == ASUB) && ((f3 == F3_ADD) || (f3 == F3_SRL))));
                writes_rd = 1'b1;
                uses_rs2  = 1'b1;
            end
            default: ;
        endcase
    end

    // Immediate assembly; illegal encodings carry no immediate
    always_comb begin
        imm_c = 32'd0;
        case (fmt)
            IMM_I: imm_c = {{20{instr.i.imm11_0[11]}}, instr.i.imm11_0};
            IMM_S: imm_c = {{20{instr.s.imm11_5[6]}}, instr.s.imm11_5, instr.s.imm4_0};
            IMM_B: imm_c = {{19{instr.b.imm12}}, instr.b.imm12, instr.b.imm11,
                            instr.b.imm10_5, instr.b.imm4_1, 1'b0};
            IMM_U: imm_c = {instr.u.imm31_12, 12'd0};
            IMM_J: imm_c = {{11{instr.j.imm20}}, instr.j.imm20, instr.j.imm19_12,
                            instr.j.imm11, instr.j.imm10_1, 1'b0};
            default: imm_c = 32'd0;
        endcase
        if (illegal_c) begin
            imm_c = 32'd0;
        end
    end

    assign opcode_c    = instr.r.opcode;
    assign funct3_c    = f3;
    assign funct7_c    = f7;
    assign rs1_c       = uses_rs1 ? instr.r.rs1 : 5'd0;
    assign rs2_c       = uses_rs2 ? instr.r.rs2 : 5'd0;
    assign rd_c        = uses_rd  ? instr.r.rd  : 5'd0;
    assign reg_write_c = !illegal_c && writes_rd && (instr.r.rd != 5'd0);

endmodule

// File: rtl/id_stage.sv
// Single-entry registered decode stage: valid/ready handshake toward fetch
// and execute, flush-priority discard, decoded fields held in registers.
module id_stage
    import typePack::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            flush,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [6:0]      id_opcode,
    output logic [2:0]      id_funct3,
    output logic [6:0]      id_funct7,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [4:0]      id_rd,
    output logic [31:0]     id_imm,
    output logic            id_reg_write,
    output logic            id_illegal
);

    instruction_t instr;
    logic [6:0]   dec_opcode;
    logic [2:0]   dec_funct3;
    logic [6:0]   dec_funct7;
    logic [4:0]   dec_rs1;
    logic [4:0]   dec_rs2;
    logic [4:0]   dec_rd;
    logic [31:0]  dec_imm;
    logic         dec_reg_write;
    logic         dec_illegal;
    logic         load;
    logic         capture;
    logic         valid_d;

    assign instr = instruction_t'(if_instr);

    id_decode u_decode (
        .instr       (instr),
        .opcode_c    (dec_opcode),
        .funct3_c    (dec_funct3),
        .funct7_c    (dec_funct7),
        .rs1_c       (dec_rs1),
        .rs2_c       (dec_rs2),
        .rd_c        (dec_rd),
        .imm_c       (dec_imm),
        .reg_write_c (dec_reg_write),
        .illegal_c   (dec_illegal)
    );

    assign if_ready = !id_valid || id_ready;

    // Flush wins over both a new load and a drain
    always_comb begin
        load    = if_valid && if_ready;
        capture = load && !flush;
        valid_d = id_valid;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
        end else if (id_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid     <= 1'b0;
            id_pc        <= '0;
            id_opcode    <= 7'd0;
            id_funct3    <= 3'd0;
            id_funct7    <= 7'd0;
            id_rs1       <= 5'd0;
            id_rs2       <= 5'd0;
            id_rd        <= 5'd0;
            id_imm       <= 32'd0;
            id_reg_write <= 1'b0;
            id_illegal   <= 1'b0;
        end else begin
            id_valid <= valid_d;
            if (capture) begin
                id_pc        <= if_pc;
                id_opcode    <= dec_opcode;
                id_funct3    <= dec_funct3;
                id_funct7    <= dec_funct7;
                id_rs1       <= dec_rs1;
                id_rs2       <= dec_rs2;
                id_rd        <= dec_rd;
                id_imm       <= dec_imm;
                id_reg_write <= dec_reg_write;
                id_illegal   <= dec_illegal;
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode vectors, backpressure, flush and
// asynchronous reset, checked with immediate assertions.
module tb_id_stage;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [31:0] id_imm;
    logic        id_reg_write;
    logic        id_illegal;

    int errors;
    int checks;

    id_stage #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_valid     (if_valid),
        .if_ready     (if_ready),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_pc        (id_pc),
        .id_opcode    (id_opcode),
        .id_funct3    (id_funct3),
        .id_funct7    (id_funct7),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_imm       (id_imm),
        .id_reg_write (id_reg_write),
        .id_illegal   (id_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // instr, illegal, reg_write, imm
    typedef struct {
        logic [31:0] instr;
        logic        illegal;
        logic        reg_write;
        logic [31:0] imm;
    } vec_t;

    vec_t vecs[9];
    logic [31:0] hold_pc;
    logic [31:0] hold_imm;

    initial begin
        errors   = 0;
        checks   = 0;
        rst      = 1'b1;
        if_valid = 1'b0;
        if_instr = 32'd0;
        if_pc    = 32'd0;
        flush    = 1'b0;
        id_ready = 1'b1;

        vecs[0] = '{32'h40000033, 1'b0, 1'b0, 32'h0};        // SUB x0
        vecs[1] = '{32'h40001033, 1'b1, 1'b0, 32'h0};        // ASUB with SLL
        vecs[2] = '{32'h4010D093, 1'b0, 1'b1, 32'h00000401}; // SRAI x1,x1,1
        vecs[3] = '{32'h40109093, 1'b1, 1'b0, 32'h0};        // SLLI bad imm[11:5]
        vecs[4] = '{32'h000090E7, 1'b1, 1'b0, 32'h0};        // JALR funct3=1
        vecs[5] = '{32'h0000B083, 1'b1, 1'b0, 32'h0};        // load funct3=3
        vecs[6] = '{32'h00003023, 1'b1, 1'b0, 32'h0};        // store funct3=3
        vecs[7] = '{32'h00001097, 1'b0, 1'b1, 32'h00001000}; // AUIPC x1,1
        vecs[8] = '{32'h00002063, 1'b1, 1'b0, 32'h0};        // branch funct3=2

        #2;
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_if_ready", 32'(if_ready), 32'd1);
        chk("rst_id_imm", id_imm, 32'd0);
        chk("rst_id_illegal", 32'(id_illegal), 32'd0);
        chk("rst_reg_write", 32'(id_reg_write), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("post_rst_if_ready", 32'(if_ready), 32'd1);

        // ADDI x1,x0,-1
        if_valid = 1'b1; if_instr = 32'hFFF00093; if_pc = 32'h100;
        cyc();
        chk("addi_valid", 32'(id_valid), 32'd1);
        chk("addi_opcode", 32'(id_opcode), 32'h13);
        chk("addi_rd", 32'(id_rd), 32'd1);
        chk("addi_imm", id_imm, 32'hFFFFFFFF);
        chk("addi_reg_write", 32'(id_reg_write), 32'd1);
        chk("addi_pc", id_pc, 32'h100);
        chk("addi_rs2", 32'(id_rs2), 32'd0);

        // SW x2,8(x1)
        if_instr = 32'h0020A423; if_pc = 32'h104;
        cyc();
        chk("sw_rs1", 32'(id_rs1), 32'd1);
        chk("sw_rs2", 32'(id_rs2), 32'd2);
        chk("sw_rd", 32'(id_rd), 32'd0);
        chk("sw_imm", id_imm, 32'd8);
        chk("sw_reg_write", 32'(id_reg_write), 32'd0);
        chk("sw_funct3", 32'(id_funct3), 32'd2);

        // BEQ -4
        if_instr = 32'hFE000EE3; if_pc = 32'h108;
        cyc();
        chk("beq_imm", id_imm, 32'hFFFFFFFC);
        chk("beq_rd", 32'(id_rd), 32'd0);
        chk("beq_illegal", 32'(id_illegal), 32'd0);

        // JAL x1,2048
        if_instr = 32'h001000EF; if_pc = 32'h10C;
        cyc();
        chk("jal_imm", id_imm, 32'h00000800);
        chk("jal_rs1", 32'(id_rs1), 32'd0);
        chk("jal_reg_write", 32'(id_reg_write), 32'd1);
        chk("jal_rd", 32'(id_rd), 32'd1);

        // Backpressure: hold ADDI at 0x200 while LUI x5 waits
        if_instr = 32'hFFF00093; if_pc = 32'h200;
        cyc();
        id_ready = 1'b0;
        if_instr = 32'h123452B7; if_pc = 32'h204;
        hold_pc  = 32'h200;
        hold_imm = 32'hFFFFFFFF;
        #1;
        chk("bp_if_ready", 32'(if_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("bp_if_ready_hold", 32'(if_ready), 32'd0);
            chk("bp_pc_hold", id_pc, hold_pc);
            chk("bp_imm_hold", id_imm, hold_imm);
            chk("bp_valid_hold", 32'(id_valid), 32'd1);
        end
        id_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(if_ready), 32'd1);
        cyc();
        chk("lui_pc", id_pc, 32'h204);
        chk("lui_imm", id_imm, 32'h12345000);
        chk("lui_rs1", 32'(id_rs1), 32'd0);
        chk("lui_rd", 32'(id_rd), 32'd5);
        chk("lui_reg_write", 32'(id_reg_write), 32'd1);

        // Flush and load in the same cycle
        if_instr = 32'hFFF00093; if_pc = 32'h300; flush = 1'b1;
        cyc();
        flush = 1'b0;
        if_valid = 1'b0;
        chk("flush_valid", 32'(id_valid), 32'd0);
        chk("flush_if_ready", 32'(if_ready), 32'd1);

        // Drain with no new load clears valid
        if_valid = 1'b1; if_instr = 32'h00000000; if_pc = 32'h400;
        cyc();
        chk("zero_valid", 32'(id_valid), 32'd1);
        chk("zero_illegal", 32'(id_illegal), 32'd1);
        chk("zero_reg_write", 32'(id_reg_write), 32'd0);
        chk("zero_imm", id_imm, 32'd0);
        if_valid = 1'b0;
        cyc();
        chk("drain_valid", 32'(id_valid), 32'd0);

        // Legality / immediate table
        if_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if_instr = vecs[k].instr;
            if_pc    = 32'h500 + 32'(k * 4);
            cyc();
            chk($sformatf("tbl%0d_illegal", k), 32'(id_illegal), 32'(vecs[k].illegal));
            chk($sformatf("tbl%0d_reg_write", k), 32'(id_reg_write), 32'(vecs[k].reg_write));
            chk($sformatf("tbl%0d_imm", k), id_imm, vecs[k].imm);
        end

        // Asynchronous reset between edges with an instruction held
        if_instr = 32'hFFF00093; if_pc = 32'h600;
        cyc();
        if_valid = 1'b0;
        chk("pre_rst_valid", 32'(id_valid), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(id_valid), 32'd0);
        chk("async_rst_if_ready", 32'(if_ready), 32'd1);
        chk("async_rst_pc", id_pc, 32'd0);
        chk("async_rst_reg_write", 32'(id_reg_write), 32'd0);
        #2;
        rst = 1'b0;
        cyc();
        chk("after_rst_valid", 32'(id_valid), 32'd0);
        chk("after_rst_imm", id_imm, 32'd0);
        chk("after_rst_if_ready", 32'(if_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
